// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the iterative single-precision significand multiplier.
// Holds the FSM encoding, format constants and the operand-pair special-case classifier.
package fp_mul_pkg;

  localparam int unsigned BIAS   = 127;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned PROD_W = 48;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StMult,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ClsNormal,
    ClsZero,
    ClsInf,
    ClsNan
  } cls_e;

  // NaN dominates (including inf x zero), then inf, then zero.
  function automatic cls_e classify_pair(input logic zero_a, input logic inf_a,
                                         input logic nan_a, input logic zero_b,
                                         input logic inf_b, input logic nan_b);
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      return ClsNan;
    end else if (inf_a || inf_b) begin
      return ClsInf;
    end else if (zero_a || zero_b) begin
      return ClsZero;
    end
    return ClsNormal;
  endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// Combinational decode of one IEEE-754 single word into sign, exponent, significand and
// special-case flags; denormals are flushed to zero.
module fp_operand_classify
  import fp_mul_pkg::*;
(
  input  logic [31:0]      word,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] significand,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  logic [FRAC_W-1:0] frac;
  logic              exp_min;
  logic              exp_max;

  assign sign    = word[31];
  assign exp     = word[30:23];
  assign frac    = word[FRAC_W-1:0];
  assign exp_min = (exp == '0);
  assign exp_max = (exp == '1);

  assign is_zero     = exp_min;
  assign is_inf      = exp_max && (frac == '0);
  assign is_nan      = exp_max && (frac != '0);
  assign significand = exp_min ? '0 : {1'b1, frac};

endmodule

// File: rtl/fp_sig_mult_iter.sv
// Radix-2 shift-add significand multiplier for IEEE-754 single: one partial product per
// cycle, with sign, biased exponent sum and special-case flags for the downstream stage.
module fp_sig_mult_iter
  import fp_mul_pkg::*;
#(
  parameter int unsigned MANT_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product,
  output logic              product_msb,
  output logic [9:0]        exp_sum,
  output logic              sign,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  localparam logic [4:0] CntLast = 5'(MANT_W - 1);

  state_e state_q, state_d;

  logic [31:0]       a_q, b_q;
  logic [PROD_W-1:0] acc_q, acc_d, acc_sum;
  logic [4:0]        cnt_q, cnt_d;
  logic              opnd_en, res_en;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic             zero_a, inf_a, nan_a, zero_b, inf_b, nan_b;
  cls_e             cls;
  logic [9:0]       exp_calc;

  logic [PROD_W-1:0] product_q;
  logic [9:0]        exp_sum_q;
  logic              sign_q, is_zero_q, is_inf_q, is_nan_q;

  fp_operand_classify u_cls_a (
    .word        (a_q),
    .sign        (sign_a),
    .exp         (exp_a),
    .significand (sig_a),
    .is_zero     (zero_a),
    .is_inf      (inf_a),
    .is_nan      (nan_a)
  );

  fp_operand_classify u_cls_b (
    .word        (b_q),
    .sign        (sign_b),
    .exp         (exp_b),
    .significand (sig_b),
    .is_zero     (zero_b),
    .is_inf      (inf_b),
    .is_nan      (nan_b)
  );

  // Operands stay latched for the whole operation, so the decode is stable from LOAD to DONE.
  assign cls      = classify_pair(zero_a, inf_a, nan_a, zero_b, inf_b, nan_b);
  assign exp_calc = {2'b00, exp_a} + {2'b00, exp_b} - 10'(BIAS);
  assign acc_sum  = acc_q + (sig_b[cnt_q] ? ({{(PROD_W - SIG_W){1'b0}}, sig_a} << cnt_q)
                                          : '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    opnd_en = 1'b0;
    res_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opnd_en = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (cls != ClsNormal) begin
          res_en  = 1'b1;
          state_d = StDone;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMult;
        end
      end
      StMult: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CntLast) begin
          res_en  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (opnd_en) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  // Final MULT iteration lands straight in the product register via acc_sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product_q <= '0;
      exp_sum_q <= '0;
      sign_q    <= 1'b0;
      is_zero_q <= 1'b0;
      is_inf_q  <= 1'b0;
      is_nan_q  <= 1'b0;
    end else if (res_en) begin
      product_q <= (cls == ClsNormal) ? acc_sum : '0;
      exp_sum_q <= (cls == ClsNormal) ? exp_calc : '0;
      sign_q    <= sign_a ^ sign_b;
      is_zero_q <= (cls == ClsZero);
      is_inf_q  <= (cls == ClsInf);
      is_nan_q  <= (cls == ClsNan);
    end
  end

  assign busy        = (state_q == StLoad) || (state_q == StMult);
  assign done        = (state_q == StDone);
  assign product     = product_q;
  assign product_msb = product_q[PROD_W-1];
  assign exp_sum     = exp_sum_q;
  assign sign        = sign_q;
  assign is_zero     = is_zero_q;
  assign is_inf      = is_inf_q;
  assign is_nan      = is_nan_q;

endmodule
